// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the single-word host port of the SDRAM controller between NUM_PORTS
// requesters (CPU, video, DMA, ...). Arbitration is round-robin, and only one
// transaction is in flight at a time. After each enable the block waits a
// fixed latency, then sends a one-cycle ack (plus read data) back to the
// winner. A short idle gap after each ack lets the controller settle before
// the next command.

module sdram_port_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int HADDR_WIDTH = 24,
  parameter int RD_LATENCY  = 8,
  parameter int WR_LATENCY  = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             port_req,
  input  logic [NUM_PORTS-1:0]             port_we,
  input  logic [NUM_PORTS*HADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*16-1:0]          port_wdata,
  output logic [NUM_PORTS-1:0]             port_ack,
  output logic [15:0]                      port_rdata,
  output logic [1:0]                       grant_id,
  output logic [HADDR_WIDTH-1:0]           ctrl_haddr,
  output logic [15:0]                      ctrl_data_input,
  output logic                             ctrl_rd_enable,
  output logic                             ctrl_wr_enable,
  input  logic [15:0]                      ctrl_data_output,
  input  logic                             ctrl_busy
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0]       LAST_PORT = 2'(NUM_PORTS - 1);
  localparam logic [3:0]       GAP_LOAD  = 4'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_LATENCY - 1);

  logic [1:0]             state;
  logic [1:0]             last_grant;
  logic [3:0]             gap_cnt;
  logic [CNT_W-1:0]       lat_cnt;
  logic                   op_we;

  logic                   any_req;
  logic                   win_found;
  logic [1:0]             win_id;
  int                     cand;
  logic                   sel_we;
  logic [HADDR_WIDTH-1:0] sel_addr;
  logic [15:0]            sel_wdata;
  logic [NUM_PORTS-1:0]   ack_onehot;
  logic                   arb_fire;
  logic                   wait_done;

  assign any_req   = |port_req;
  assign arb_fire  = (state == IDLE) && (gap_cnt == 4'd0) && any_req && !ctrl_busy;
  assign wait_done = (state == WAIT) && (lat_cnt == '0) && !ctrl_busy;

  // Round-robin pick: first requester after last_grant, wrapping modulo NUM_PORTS.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    cand      = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!win_found && (i == cand) && port_req[i]) begin
          win_found = 1'b1;
          win_id    = 2'(i);
        end
      end
    end
  end

  // Route the winning port's operation fields toward the command registers.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (2'(i) == win_id) begin
        sel_we    = port_we[i];
        sel_addr  = port_addr[i*HADDR_WIDTH +: HADDR_WIDTH];
        sel_wdata = port_wdata[i*16 +: 16];
      end
    end
  end

  // One-hot decode of the port currently being served, used for the ack pulse.
  always_comb begin
    ack_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ack_onehot[i] = (2'(i) == grant_id);
    end
  end

  // Transaction sequencing: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (arb_fire)  state <= ISSUE;
        ISSUE:   state <= WAIT;
        WAIT:    if (wait_done) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Fairness pointer and post-ack idle gap; the gap drains even while busy holds off arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= LAST_PORT;
      gap_cnt    <= 4'd0;
    end else if (state == DONE) begin
      last_grant <= grant_id;
      gap_cnt    <= GAP_LOAD;
    end else if ((state == IDLE) && (gap_cnt != 4'd0)) begin
      gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // Latency counter: loaded while the enable is out, then counts down to zero and parks there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (state == ISSUE) begin
      lat_cnt <= op_we ? WR_LOAD : RD_LOAD;
    end else if ((state == WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Capture the winner's operation; these hold steady for the whole transaction and after it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_haddr      <= '0;
      ctrl_data_input <= '0;
      op_we           <= 1'b0;
      grant_id        <= 2'd0;
    end else if (arb_fire) begin
      ctrl_haddr      <= sel_addr;
      ctrl_data_input <= sel_wdata;
      op_we           <= sel_we;
      grant_id        <= win_id;
    end
  end

  // Command strobes: exactly one cycle, high during ISSUE, read or write never both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_rd_enable <= 1'b0;
      ctrl_wr_enable <= 1'b0;
    end else begin
      ctrl_rd_enable <= arb_fire && !sel_we;
      ctrl_wr_enable <= arb_fire && sel_we;
    end
  end

  // Completion: read data sampled on the edge leaving WAIT, ack pulses during DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      port_ack   <= '0;
      port_rdata <= '0;
    end else begin
      port_ack <= wait_done ? ack_onehot : '0;
      if (wait_done && !op_we) begin
        port_rdata <= ctrl_data_output;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
// Drives a 2-port arbiter (default parameters) against a transaction-level
// reference model, and drives a 4-port arbiter for the sparse-requester case.

module tb_sdram_port_arbiter;

  localparam int N      = 2;
  localparam int RD_LAT = 8;
  localparam int WR_LAT = 4;
  localparam int GAP    = 2;
  localparam int RD4    = 3;
  localparam int WR4    = 2;
  localparam int GAP4   = 0;

  logic        clk;
  logic        rst_n;

  logic [1:0]  port_req, port_we, port_ack, grant_id;
  logic [47:0] port_addr;
  logic [31:0] port_wdata;
  logic [15:0] port_rdata, ctrl_data_input, ctrl_data_output;
  logic [23:0] ctrl_haddr;
  logic        ctrl_rd_enable, ctrl_wr_enable, ctrl_busy;

  logic [3:0]  req4, we4, ack4;
  logic [95:0] addr4;
  logic [63:0] wdata4;
  logic [15:0] rdata4, din4, dout4;
  logic [1:0]  grant4;
  logic [23:0] haddr4;
  logic        rd4, wr4, busy4;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: one transaction timeline
  bit          m_active;
  int          m_port, m_issue, m_ack, m_next_arb, m_last;
  logic        m_we;
  logic [23:0] m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [1:0]  m_grant;

  logic        exp_rd, exp_wr;
  logic [1:0]  exp_ack, exp_grant;
  logic [15:0] exp_rdata, exp_din;
  logic [23:0] exp_haddr;

  sdram_port_arbiter #(
    .NUM_PORTS(N), .HADDR_WIDTH(24), .RD_LATENCY(RD_LAT),
    .WR_LATENCY(WR_LAT), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_ack(port_ack), .port_rdata(port_rdata),
    .grant_id(grant_id), .ctrl_haddr(ctrl_haddr), .ctrl_data_input(ctrl_data_input),
    .ctrl_rd_enable(ctrl_rd_enable), .ctrl_wr_enable(ctrl_wr_enable),
    .ctrl_data_output(ctrl_data_output), .ctrl_busy(ctrl_busy)
  );

  sdram_port_arbiter #(
    .NUM_PORTS(4), .HADDR_WIDTH(24), .RD_LATENCY(RD4),
    .WR_LATENCY(WR4), .GAP_CYCLES(GAP4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n),
    .port_req(req4), .port_we(we4), .port_addr(addr4),
    .port_wdata(wdata4), .port_ack(ack4), .port_rdata(rdata4),
    .grant_id(grant4), .ctrl_haddr(haddr4), .ctrl_data_input(din4),
    .ctrl_rd_enable(rd4), .ctrl_wr_enable(wr4),
    .ctrl_data_output(dout4), .ctrl_busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // controller memory contents as seen by reads
  function automatic logic [15:0] rd_value(input logic [23:0] a);
    if (a == 24'h000123) return 16'hBEEF;
    return {a[7:0] ^ a[23:16], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic set_port(input int p, input logic we, input logic [23:0] a, input logic [15:0] d);
    port_req[p]            = 1'b1;
    port_we[p]             = we;
    port_addr[p*24 +: 24]  = a;
    port_wdata[p*16 +: 16] = d;
  endtask

  // Advance one clock: the model consumes this cycle's inputs, then expectations
  // for the next cycle are formed and the controller data line is driven.
  task automatic tick();
    int win;
    if (!rst_n) begin
      m_active   = 0;
      m_last     = N - 1;
      m_next_arb = cyc + 1;
      m_ack      = -1;
      m_rdata    = '0;
      m_addr     = '0;
      m_wdata    = '0;
      m_grant    = '0;
    end else if (!m_active) begin
      if (cyc >= m_next_arb && port_req != 2'b00 && !ctrl_busy) begin
        win = -1;
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && port_req[(m_last + k) % N]) win = (m_last + k) % N;
        end
        m_active = 1;
        m_port   = win;
        m_we     = port_we[win];
        m_addr   = port_addr[win*24 +: 24];
        m_wdata  = port_wdata[win*16 +: 16];
        m_grant  = 2'(win);
        m_issue  = cyc + 1;
        m_ack    = -1;
      end
    end else if (m_ack < 0) begin
      if (cyc >= m_issue + (m_we ? WR_LAT : RD_LAT) && !ctrl_busy) begin
        m_ack = cyc + 1;
        if (!m_we) m_rdata = ctrl_data_output;
      end
    end else if (cyc == m_ack) begin
      m_active   = 0;
      m_last     = m_port;
      m_next_arb = m_ack + 1 + GAP;
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_rd    = m_active && (m_issue == cyc) && !m_we;
    exp_wr    = m_active && (m_issue == cyc) && m_we;
    exp_ack   = (m_active && m_ack == cyc) ? 2'(1 << m_port) : 2'b00;
    exp_rdata = m_rdata;
    exp_haddr = m_addr;
    exp_din   = m_wdata;
    exp_grant = m_grant;
    if (m_active && !m_we && cyc >= m_issue + RD_LAT) ctrl_data_output = rd_value(m_addr);
    else ctrl_data_output = 16'($urandom);
  endtask

  task automatic idle(input int n);
    port_req = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    port_req = 2'b00;
    req4 = 4'h0;
    tick();
    tick();
    checks++; if (ctrl_rd_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: got %b want 0", ctrl_rd_enable); end
    checks++; if (ctrl_wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr: got %b want 0", ctrl_wr_enable); end
    checks++; if (port_ack !== 2'b00) begin errors++; $display("[TB] FAIL reset_ack: got %b want 00", port_ack); end
    checks++; if (port_rdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", port_rdata); end
    checks++; if (ctrl_haddr !== 24'h0) begin errors++; $display("[TB] FAIL reset_haddr: got %h want 0", ctrl_haddr); end
    checks++; if (ctrl_data_input !== 16'h0) begin errors++; $display("[TB] FAIL reset_din: got %h want 0", ctrl_data_input); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant: got %0d want 0", grant_id); end
    checks++; if ({rd4, wr4, ack4, rdata4, haddr4, din4, grant4} !== '0) begin errors++; $display("[TB] FAIL reset_dut4: outputs not all zero"); end
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    set_port(0, 1'b0, 24'h000123, 16'h1111);
    for (int r = 1; r <= 13; r++) begin
      tick();
      checks++; if (ctrl_rd_enable !== (r == 1)) begin errors++; $display("[TB] FAIL read_rd_en r=%0d: got %b want %b", r, ctrl_rd_enable, (r == 1)); end
      checks++; if (ctrl_wr_enable !== 1'b0) begin errors++; $display("[TB] FAIL read_wr_en r=%0d: got %b want 0", r, ctrl_wr_enable); end
      checks++; if (port_ack !== ((r == 10) ? 2'b01 : 2'b00)) begin errors++; $display("[TB] FAIL read_ack r=%0d: got %b", r, port_ack); end
      if (r == 1) begin
        checks++; if (ctrl_haddr !== 24'h000123) begin errors++; $display("[TB] FAIL read_haddr: got %h want 000123", ctrl_haddr); end
      end
      if (r == 10) begin
        checks++; if (port_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL read_rdata: got %h want BEEF", port_rdata); end
      end
      if (port_ack[0]) port_req[0] = 1'b0;
    end
  endtask

  task automatic test_write();
    idle(4);
    port_addr[23:0] = 24'($urandom);
    set_port(1, 1'b1, 24'h3FFFFF, 16'hA5A5);
    for (int r = 1; r <= 9; r++) begin
      tick();
      checks++; if (ctrl_wr_enable !== (r == 1)) begin errors++; $display("[TB] FAIL write_wr_en r=%0d: got %b want %b", r, ctrl_wr_enable, (r == 1)); end
      checks++; if (ctrl_rd_enable !== 1'b0) begin errors++; $display("[TB] FAIL write_rd_en r=%0d: got %b want 0", r, ctrl_rd_enable); end
      checks++; if (port_ack !== ((r == 6) ? 2'b10 : 2'b00)) begin errors++; $display("[TB] FAIL write_ack r=%0d: got %b", r, port_ack); end
      if (r == 1) begin
        checks++; if (ctrl_haddr !== 24'h3FFFFF) begin errors++; $display("[TB] FAIL write_haddr: got %h want 3FFFFF", ctrl_haddr); end
        checks++; if (ctrl_data_input !== 16'hA5A5) begin errors++; $display("[TB] FAIL write_din: got %h want A5A5", ctrl_data_input); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("[TB] FAIL write_grant: got %0d want 1", grant_id); end
      end
      if (r == 6) begin
        checks++; if (port_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL write_rdata_kept: got %h want BEEF", port_rdata); end
      end
      if (port_ack[1]) port_req[1] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int c0, n_ack, n_en, last_ack, last_en;
    int opn [2];
    opn[0] = 0;
    opn[1] = 0;
    rst_n = 1'b0;
    set_port(0, 1'b0, 24'h100000, 16'h0);
    set_port(1, 1'b0, 24'h200000, 16'h0);
    tick();
    rst_n = 1'b1;
    c0 = cyc;
    n_ack = 0; n_en = 0; last_ack = 0; last_en = 0;
    for (int r = 1; r <= 80 && n_ack < 4; r++) begin
      tick();
      if (ctrl_rd_enable || ctrl_wr_enable) begin
        if (n_en == 0) begin
          checks++; if (cyc - c0 !== 1) begin errors++; $display("[TB] FAIL b2b_first_enable: got rel %0d want 1", cyc - c0); end
        end else begin
          checks++; if (cyc - last_ack !== GAP + 2) begin errors++; $display("[TB] FAIL b2b_gap: got %0d want %0d", cyc - last_ack, GAP + 2); end
        end
        checks++; if (grant_id !== 2'(n_en % 2)) begin errors++; $display("[TB] FAIL b2b_grant: got %0d want %0d", grant_id, n_en % 2); end
        last_en = cyc;
        n_en++;
      end
      if (port_ack != 2'b00) begin
        checks++; if (port_ack !== 2'(1 << (n_ack % 2))) begin errors++; $display("[TB] FAIL b2b_order: got %b want port %0d", port_ack, n_ack % 2); end
        checks++; if (cyc - last_en !== RD_LAT + 1) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want %0d", cyc - last_en, RD_LAT + 1); end
        for (int p = 0; p < 2; p++) begin
          if (port_ack[p]) begin
            checks++; if (port_rdata !== rd_value(port_addr[p*24 +: 24])) begin errors++; $display("[TB] FAIL b2b_rdata: got %h want %h", port_rdata, rd_value(port_addr[p*24 +: 24])); end
            opn[p]++;
            port_addr[p*24 +: 24] = 24'(((p + 1) << 20) + opn[p]);
          end
        end
        last_ack = cyc;
        n_ack++;
      end
    end
    checks++; if (n_ack !== 4) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d acks want 4", n_ack); end
    port_req = 2'b00;
  endtask

  task automatic test_busy_extend();
    int n_en;
    idle(4);
    n_en = 0;
    set_port(0, 1'b0, 24'h00C0FE, 16'h0);
    for (int r = 1; r <= 20; r++) begin
      tick();
      if (ctrl_rd_enable || ctrl_wr_enable) n_en++;
      checks++; if (port_ack !== ((r == 15) ? 2'b01 : 2'b00)) begin errors++; $display("[TB] FAIL busy_ack r=%0d: got %b", r, port_ack); end
      if (r == 15) begin
        checks++; if (port_rdata !== rd_value(24'h00C0FE)) begin errors++; $display("[TB] FAIL busy_rdata: got %h want %h", port_rdata, rd_value(24'h00C0FE)); end
      end
      if (port_ack[0]) port_req[0] = 1'b0;
      ctrl_busy = (r >= 9 && r <= 13);
    end
    ctrl_busy = 1'b0;
    checks++; if (n_en !== 1) begin errors++; $display("[TB] FAIL busy_enables: got %0d want 1", n_en); end
  endtask

  task automatic test_reset_mid_wait();
    int n_ack, stray;
    idle(4);
    set_port(1, 1'b0, 24'h0ABCDE, 16'h0);
    for (int r = 1; r <= 5; r++) tick();
    rst_n = 1'b0;
    port_req = 2'b00;
    tick();
    checks++; if ({ctrl_rd_enable, ctrl_wr_enable, port_ack, port_rdata, ctrl_haddr, ctrl_data_input, grant_id} !== '0) begin
      errors++; $display("[TB] FAIL midreset_outputs: rd=%b wr=%b ack=%b rdata=%h haddr=%h din=%h grant=%0d",
        ctrl_rd_enable, ctrl_wr_enable, port_ack, port_rdata, ctrl_haddr, ctrl_data_input, grant_id);
    end
    rst_n = 1'b1;
    stray = 0;
    for (int r = 0; r < 18; r++) begin
      tick();
      if (port_ack != 2'b00 || ctrl_rd_enable || ctrl_wr_enable) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL midreset_stray_activity: got %0d cycles want 0", stray); end
    set_port(0, 1'b0, 24'h111111, 16'h0);
    set_port(1, 1'b0, 24'h222222, 16'h0);
    tick();
    checks++; if (ctrl_rd_enable !== 1'b1) begin errors++; $display("[TB] FAIL midreset_enable: got %b want 1", ctrl_rd_enable); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL midreset_grant: got %0d want 0", grant_id); end
    checks++; if (ctrl_haddr !== 24'h111111) begin errors++; $display("[TB] FAIL midreset_haddr: got %h want 111111", ctrl_haddr); end
    n_ack = 0;
    for (int r = 0; r < 40 && n_ack < 2; r++) begin
      tick();
      if (port_ack != 2'b00) begin
        checks++; if (port_ack !== 2'(1 << n_ack)) begin errors++; $display("[TB] FAIL midreset_order: got %b want port %0d", port_ack, n_ack); end
        port_req = port_req & ~port_ack;
        n_ack++;
      end
    end
    checks++; if (n_ack !== 2) begin errors++; $display("[TB] FAIL midreset_timeout: got %0d acks want 2", n_ack); end
    port_req = 2'b00;
  endtask

  task automatic test_four_ports();
    int n, last_ack, exp_p, want;
    busy4 = 1'b0;
    we4 = 4'b1000;
    addr4 = {24'h0000A3, 24'h0000A2, 24'($urandom), 24'($urandom)};
    wdata4 = {16'h3333, 16'h2222, 16'($urandom), 16'($urandom)};
    dout4 = 16'hC0DE;
    req4 = 4'b1100;
    last_ack = cyc;
    exp_p = 2;
    n = 0;
    for (int r = 1; r <= 80 && n < 6; r++) begin
      tick();
      if (ack4 != 4'h0) begin
        want = ((n == 0) ? 2 : 3) + ((exp_p == 2) ? RD4 : WR4);
        checks++; if (ack4 !== 4'(1 << exp_p)) begin errors++; $display("[TB] FAIL four_order: got %b want port %0d", ack4, exp_p); end
        checks++; if (cyc - last_ack !== want) begin errors++; $display("[TB] FAIL four_timing: got %0d want %0d", cyc - last_ack, want); end
        checks++; if (rdata4 !== 16'hC0DE) begin errors++; $display("[TB] FAIL four_rdata: got %h want C0DE", rdata4); end
        last_ack = cyc;
        exp_p = (exp_p == 2) ? 3 : 2;
        n++;
      end
    end
    checks++; if (n !== 6) begin errors++; $display("[TB] FAIL four_timeout: got %0d acks want 6", n); end
    req4 = 4'h0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 600; r++) begin
      tick();
      checks++; if (ctrl_rd_enable !== exp_rd) begin errors++; $display("[TB] FAIL rand_rd_en cyc=%0d: got %b want %b", cyc, ctrl_rd_enable, exp_rd); end
      checks++; if (ctrl_wr_enable !== exp_wr) begin errors++; $display("[TB] FAIL rand_wr_en cyc=%0d: got %b want %b", cyc, ctrl_wr_enable, exp_wr); end
      checks++; if (port_ack !== exp_ack) begin errors++; $display("[TB] FAIL rand_ack cyc=%0d: got %b want %b", cyc, port_ack, exp_ack); end
      checks++; if (port_rdata !== exp_rdata) begin errors++; $display("[TB] FAIL rand_rdata cyc=%0d: got %h want %h", cyc, port_rdata, exp_rdata); end
      checks++; if (ctrl_haddr !== exp_haddr) begin errors++; $display("[TB] FAIL rand_haddr cyc=%0d: got %h want %h", cyc, ctrl_haddr, exp_haddr); end
      checks++; if (ctrl_data_input !== exp_din) begin errors++; $display("[TB] FAIL rand_din cyc=%0d: got %h want %h", cyc, ctrl_data_input, exp_din); end
      checks++; if (grant_id !== exp_grant) begin errors++; $display("[TB] FAIL rand_grant cyc=%0d: got %0d want %0d", cyc, grant_id, exp_grant); end
      for (int p = 0; p < N; p++) begin
        if (port_req[p] && port_ack[p]) begin
          if ($urandom_range(0, 1) == 1) set_port(p, 1'($urandom), 24'($urandom), 16'($urandom));
          else port_req[p] = 1'b0;
        end else if (!port_req[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_port(p, 1'($urandom), 24'($urandom), 16'($urandom));
          end else begin
            port_we[p] = 1'($urandom);
            port_addr[p*24 +: 24] = 24'($urandom);
            port_wdata[p*16 +: 16] = 16'($urandom);
          end
        end
      end
      ctrl_busy = ($urandom_range(0, 3) == 0);
    end
    port_req = 2'b00;
    ctrl_busy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    port_req = '0; port_we = '0; port_addr = '0; port_wdata = '0;
    ctrl_busy = 1'b0; ctrl_data_output = '0;
    req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0; dout4 = '0; busy4 = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_busy_extend();
    test_reset_mid_wait();
    test_four_ports();
    test_random();
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
